// File: rtl/key_pulser_pkg.sv
// Shared FSM state type and default timing constants for the key pulser.
// Auto-repeat support is enabled by defining KEY_PULSER_AUTOREPEAT_EN.
package key_pulser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HELD   = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Terminal counts below 2 would allow back-to-back pulses.
    function automatic int atleast2(input int a);
        return (a < 2) ? 2 : a;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus run-length debounce producing the held level.
// pressed_nxt exposes the value pressed takes at the coming edge.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic nclr,
    input  logic btn_n,
    output logic pressed,
    output logic pressed_nxt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          lvl;
    logic          hit;

    assign lvl = ~sync[1];
    assign hit = (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        cnt_nxt     = '0;
        pressed_nxt = pressed;
        if (lvl != pressed) begin
            if (hit) begin
                pressed_nxt = lvl;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nclr) begin
            sync    <= 2'b11;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            sync    <= {sync[0], btn_n};
            cnt     <= cnt_nxt;
            pressed <= pressed_nxt;
        end
    end

endmodule

// File: rtl/key_pulser.sv
// Debounced push-button to single-cycle count-enable strobe.
// Define KEY_PULSER_AUTOREPEAT_EN to compile in delayed auto-repeat.
module key_pulser
    import key_pulser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic nclr,
    input  logic btn_n,
    output logic pressed,
    output logic pulse
);

    logic   pressed_nxt;
    logic   pulse_nxt;
    state_t state;
    state_t state_nxt;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk        (clk),
        .nclr       (nclr),
        .btn_n      (btn_n),
        .pressed    (pressed),
        .pressed_nxt(pressed_nxt)
    );

`ifdef KEY_PULSER_AUTOREPEAT_EN

    localparam int DLY = atleast2(REPEAT_DELAY);
    localparam int PER = atleast2(REPEAT_PERIOD);
    localparam int TW  = $clog2(max2(DLY, PER) + 1);

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;

    // Decisions use the level pressed is about to take so a release
    // never emits a pulse in the edge it lands on.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pulse_nxt = 1'b0;
        if (!pressed_nxt) begin
            state_nxt = IDLE;
            timer_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!pressed) begin
                        pulse_nxt = 1'b1;
                        timer_nxt = '0;
                        state_nxt = DELAY;
                    end
                end
                DELAY: begin
                    if (timer == TW'(DLY - 1)) begin
                        pulse_nxt = 1'b1;
                        timer_nxt = '0;
                        state_nxt = REPEAT;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                REPEAT: begin
                    if (timer == TW'(PER - 1)) begin
                        pulse_nxt = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nclr) begin
            state <= IDLE;
            timer <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            pulse <= pulse_nxt;
        end
    end

`else

    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};

    always_comb begin
        state_nxt = state;
        pulse_nxt = 1'b0;
        if (!pressed_nxt) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!pressed) begin
                        pulse_nxt = 1'b1;
                        state_nxt = HELD;
                    end
                end
                HELD:    state_nxt = HELD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nclr) begin
            state <= IDLE;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            pulse <= pulse_nxt;
        end
    end

`endif

endmodule

// File: tb/tb_key_pulser.sv
// Randomized and directed bench for key_pulser against a press-age model.
// Compile with or without KEY_PULSER_AUTOREPEAT_EN to match the RTL build.
module tb_key_pulser;

    localparam int N  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic nclr;
    logic btn_n;
    logic pressed;
    logic pulse;

    int checks = 0;
    int errors = 0;

    bit ms1, ms2, mprs, mpulse;
    int mage;
    bit hist[$];

    always #5 clk = ~clk;

    key_pulser #(
        .DEBOUNCE_CYCLES(N),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk    (clk),
        .nclr   (nclr),
        .btn_n  (btn_n),
        .pressed(pressed),
        .pulse  (pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Pulse due at a given hold age (edges since the debounced press).
    function automatic bit rep_due(input int age);
`ifdef KEY_PULSER_AUTOREPEAT_EN
        int d;
        int p;
        d = (RD < 2) ? 2 : RD;
        p = (RP < 2) ? 2 : RP;
        return (age == d) || (age > d && ((age - d) % p) == 0);
`else
        return (age < 0);
`endif
    endfunction

    // The debounced level flips once the last N synchronized samples
    // all disagree with it; pulses follow from the hold age.
    function automatic void model_edge(input bit b, input bit r);
        bit nprs;
        bit all;
        if (!r) begin
            ms1    = 1'b1;
            ms2    = 1'b1;
            mprs   = 1'b0;
            mage   = -1;
            mpulse = 1'b0;
            hist.push_back(1'b0);
        end else begin
            hist.push_back(!ms2);
            ms2  = ms1;
            ms1  = b;
            nprs = mprs;
            if (hist.size() >= N) begin
                all = 1'b1;
                for (int i = 0; i < N; i++)
                    if (hist[hist.size() - 1 - i] == mprs) all = 1'b0;
                if (all) nprs = !mprs;
            end
            if (nprs && !mprs) begin
                mage   = 0;
                mpulse = 1'b1;
            end else if (nprs) begin
                mage++;
                mpulse = rep_due(mage);
            end else begin
                mage   = -1;
                mpulse = 1'b0;
            end
            mprs = nprs;
        end
        if (hist.size() > 64) void'(hist.pop_front());
    endfunction

    task automatic tick(input bit b, input bit r);
        @(negedge clk);
        btn_n = b;
        nclr  = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        chk("pressed", {31'd0, pressed}, {31'd0, mprs});
        chk("pulse", {31'd0, pulse}, {31'd0, mpulse});
    endtask

    task automatic run_dir(input string tag, input int lo0, input int lo1,
                           input int hb0, input int hb1, input int rs0,
                           input int rs1, input int len,
                           input logic [63:0] mask);
        bit b;
        bit r;
        for (int e = 0; e < len; e++) begin
            b = !(e >= lo0 && e <= lo1 && !(e >= hb0 && e <= hb1));
            r = !(e >= rs0 && e <= rs1);
            tick(b, r);
            chk(tag, {31'd0, pulse}, {31'd0, mask[e]});
        end
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1);
    endtask

    logic [63:0] m_clean;
    logic [63:0] m_bounce;
    logic [63:0] m_hold;
    logic [63:0] m_rst;
    bit          prev;
    bit          lvl;
    int          seg;

    initial begin
        btn_n = 1'b1;
        nclr  = 1'b0;
        mage  = -1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        chk("rst_pressed", {31'd0, pressed}, 32'd0);
        chk("rst_pulse", {31'd0, pulse}, 32'd0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);

        m_clean  = 64'd1 << 5;
        m_bounce = 64'd1 << 10;
`ifdef KEY_PULSER_AUTOREPEAT_EN
        m_hold = (64'd1 << 5) | (64'd1 << 15) | (64'd1 << 18)
               | (64'd1 << 21) | (64'd1 << 24) | (64'd1 << 27)
               | (64'd1 << 30) | (64'd1 << 33);
        m_rst  = (64'd1 << 5) | (64'd1 << 15) | (64'd1 << 23)
               | (64'd1 << 33) | (64'd1 << 36) | (64'd1 << 39)
               | (64'd1 << 42);
`else
        m_hold = 64'd1 << 5;
        m_rst  = (64'd1 << 5) | (64'd1 << 23);
`endif
        run_dir("clean", 0, 11, -1, -2, -1, -2, 20, m_clean);
        run_dir("bounce", 0, 13, 3, 4, -1, -2, 24, m_bounce);
        run_dir("hold30", 0, 29, -1, -2, -1, -2, 40, m_hold);
        run_dir("rst_mid", 0, 39, -1, -2, 16, 17, 50, m_rst);

        prev = 1'b0;
        for (int s = 0; s < 300; s++) begin
            lvl = 1'($urandom_range(0, 1));
            seg = $urandom_range(1, 40);
            for (int c = 0; c < seg; c++) begin
                if ($urandom_range(0, 199) == 0) tick(lvl, 1'b0);
                else tick(lvl, 1'b1);
                chk("no_b2b", {31'd0, pulse & prev}, 32'd0);
                prev = pulse;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
